// File: rtl/rotary_hex_counter.sv
// Rotary encoder front end: sync, debounce, quadrature decode,
// up/down counter and registered seven-segment hex display.
module rotary_hex_counter #(
    parameter int DIGITS          = 2,
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int EDGES_PER_STEP  = 4,
    parameter int STEP            = 1,
    parameter int WRAP            = 1,
    parameter int SEG_ACTIVE_LOW  = 1
) (
    input  logic                  clk_clk,
    input  logic                  reset_reset_n,
    input  logic [1:0]            rotary_in,
    input  logic                  clear,
    output logic                  rotary_cw,
    output logic                  rotary_ccw,
    output logic [4*DIGITS-1:0]   count,
    output logic [7*DIGITS-1:0]   led_pins
);

    localparam int CW  = 4 * DIGITS;
    localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DBW-1:0]    DB_LIM = DBW'(DEBOUNCE_CYCLES);
    localparam logic signed [3:0] EPS    = 4'(EDGES_PER_STEP);
    localparam logic [CW-1:0]     STEP_V = CW'(STEP);
    localparam logic [CW-1:0]     MAX_V  = {CW{1'b1}};

    function automatic logic [1:0] gray_pos(input logic [1:0] g);
        return {g[1], g[1] ^ g[0]};
    endfunction

    function automatic logic [6:0] seg_hex(input logic [3:0] n);
        logic [6:0] s;
        unique case (n)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            4'hF: s = 7'h71;
        endcase
        return (SEG_ACTIVE_LOW != 0) ? ~s : s;
    endfunction

    logic [1:0]          sync1, sync2, sync_q;
    logic [1:0]          deb, deb_old;
    logic                deb_upd;
    logic [DBW-1:0]      db_cnt, db_next;
    logic signed [3:0]   acc, acc_nxt, acc_sum;
    logic [1:0]          step_d;
    logic                evt_cw, evt_ccw, evt_cw_nxt, evt_ccw_nxt;
    logic [CW-1:0]       count_nxt;
    logic [7*DIGITS-1:0] led_nxt;

    // sync_q holds the previous synced value so any change restarts the count
    assign db_next = (sync2 != sync_q) ? DBW'(1) : db_cnt + 1'b1;

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            sync1   <= '0;
            sync2   <= '0;
            sync_q  <= '0;
            deb     <= '0;
            deb_old <= '0;
            deb_upd <= 1'b0;
            db_cnt  <= '0;
        end else begin
            sync1   <= rotary_in;
            sync2   <= sync1;
            sync_q  <= sync2;
            deb_upd <= 1'b0;
            if (sync2 == deb) begin
                db_cnt <= '0;
            end else if (db_next >= DB_LIM) begin
                deb     <= sync2;
                deb_old <= deb;
                deb_upd <= 1'b1;
                db_cnt  <= '0;
            end else begin
                db_cnt <= db_next;
            end
        end
    end

    always_comb begin
        acc_nxt     = acc;
        acc_sum     = acc;
        evt_cw_nxt  = 1'b0;
        evt_ccw_nxt = 1'b0;
        step_d      = gray_pos(deb) - gray_pos(deb_old);
        if (deb_upd) begin
            unique case (1'b1)
                (step_d == 2'd1): acc_sum = acc + 4'sd1;
                (step_d == 2'd3): acc_sum = acc - 4'sd1;
                default:          acc_sum = '0;
            endcase
            acc_nxt = acc_sum;
            if (acc_sum == EPS) begin
                acc_nxt    = '0;
                evt_cw_nxt = 1'b1;
            end else if (acc_sum == -EPS) begin
                acc_nxt     = '0;
                evt_ccw_nxt = 1'b1;
            end
        end
        if (clear) acc_nxt = '0;
    end

    always_comb begin
        count_nxt = count;
        if (clear) begin
            count_nxt = '0;
        end else if (evt_cw) begin
            if (WRAP != 0 || count <= MAX_V - STEP_V)
                count_nxt = count + STEP_V;
            else
                count_nxt = MAX_V;
        end else if (evt_ccw) begin
            if (WRAP != 0 || count >= STEP_V)
                count_nxt = count - STEP_V;
            else
                count_nxt = '0;
        end
    end

    always_comb begin
        led_nxt = '0;
        for (int d = 0; d < DIGITS; d++)
            led_nxt[7*d +: 7] = seg_hex(count_nxt[4*d +: 4] & 4'hF);
    end

    // led_pins follows count by one cycle, so it is fed from count
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            acc        <= '0;
            evt_cw     <= 1'b0;
            evt_ccw    <= 1'b0;
            rotary_cw  <= 1'b0;
            rotary_ccw <= 1'b0;
            count      <= '0;
            led_pins   <= {DIGITS{seg_hex(4'h0)}};
        end else begin
            acc        <= acc_nxt;
            evt_cw     <= evt_cw_nxt;
            evt_ccw    <= evt_ccw_nxt;
            rotary_cw  <= evt_cw;
            rotary_ccw <= evt_ccw;
            count      <= count_nxt;
            for (int d = 0; d < DIGITS; d++)
                led_pins[7*d +: 7] <= seg_hex(count[4*d +: 4]);
        end
    end

endmodule

// File: tb/tb_rotary_hex_counter.sv
// Scoreboard bench for rotary_hex_counter: a wrapping and a
// saturating instance share stimulus; detents push expected events.
module tb_rotary_hex_counter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  rotary_in = 2'b00;
    logic        clear = 1'b0;

    logic        cw_w, ccw_w, cw_s, ccw_s;
    logic [7:0]  cnt_w, cnt_s;
    logic [13:0] led_w, led_s;

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;
    int n_pulses = 0;

    logic [7:0] model_w = 8'h00;
    logic [7:0] model_s = 8'h00;

    typedef struct {
        logic       cw;
        logic [7:0] cnt_w;
        logic [7:0] cnt_s;
        int         due;
    } exp_t;

    exp_t sb[$];

    logic        led_pend = 1'b0;
    logic [13:0] led_exp_w, led_exp_s;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    rotary_hex_counter #(
        .DIGITS(2), .DEBOUNCE_CYCLES(4), .EDGES_PER_STEP(4),
        .STEP(1), .WRAP(1), .SEG_ACTIVE_LOW(1)
    ) u_wrap (
        .clk_clk(clk), .reset_reset_n(rst_n), .rotary_in(rotary_in),
        .clear(clear), .rotary_cw(cw_w), .rotary_ccw(ccw_w),
        .count(cnt_w), .led_pins(led_w)
    );

    rotary_hex_counter #(
        .DIGITS(2), .DEBOUNCE_CYCLES(4), .EDGES_PER_STEP(4),
        .STEP(1), .WRAP(0), .SEG_ACTIVE_LOW(1)
    ) u_sat (
        .clk_clk(clk), .reset_reset_n(rst_n), .rotary_in(rotary_in),
        .clear(clear), .rotary_cw(cw_s), .rotary_ccw(ccw_s),
        .count(cnt_s), .led_pins(led_s)
    );

    function automatic logic [6:0] seg_exp(input logic [3:0] n);
        logic [6:0] t;
        case (n)
            4'h0: t = 7'h3F;  4'h1: t = 7'h06;
            4'h2: t = 7'h5B;  4'h3: t = 7'h4F;
            4'h4: t = 7'h66;  4'h5: t = 7'h6D;
            4'h6: t = 7'h7D;  4'h7: t = 7'h07;
            4'h8: t = 7'h7F;  4'h9: t = 7'h6F;
            4'hA: t = 7'h77;  4'hB: t = 7'h7C;
            4'hC: t = 7'h39;  4'hD: t = 7'h5E;
            4'hE: t = 7'h79;  default: t = 7'h71;
        endcase
        return ~t;
    endfunction

    function automatic logic [13:0] led_of(input logic [7:0] c);
        return {seg_exp(c[7:4]), seg_exp(c[3:0])};
    endfunction

    // Monitor: pops the scoreboard on every pulse, checks LEDs a cycle later
    always @(negedge clk) begin
        if (led_pend) begin
            led_pend = 1'b0;
            compared++;
            if (led_w !== led_exp_w) begin
                mismatched++;
                $display("FAIL led_wrap got %h want %h", led_w, led_exp_w);
            end
            compared++;
            if (led_s !== led_exp_s) begin
                mismatched++;
                $display("FAIL led_sat got %h want %h", led_s, led_exp_s);
            end
        end
        if (rst_n && (cw_w || ccw_w || cw_s || ccw_s)) begin
            n_pulses++;
            if (sb.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_pulse at cyc %0d got %b%b%b%b want none",
                         cyc, cw_w, ccw_w, cw_s, ccw_s);
            end else begin
                exp_t e;
                e = sb.pop_front();
                compared++;
                if ({cw_w, ccw_w, cw_s, ccw_s} !== {e.cw, !e.cw, e.cw, !e.cw}) begin
                    mismatched++;
                    $display("FAIL pulse_dir got %b%b%b%b want cw=%b",
                             cw_w, ccw_w, cw_s, ccw_s, e.cw);
                end
                compared++;
                if (cyc !== e.due) begin
                    mismatched++;
                    $display("FAIL pulse_time got %0d want %0d", cyc, e.due);
                end
                compared++;
                if (cnt_w !== e.cnt_w) begin
                    mismatched++;
                    $display("FAIL count_wrap got %h want %h", cnt_w, e.cnt_w);
                end
                compared++;
                if (cnt_s !== e.cnt_s) begin
                    mismatched++;
                    $display("FAIL count_sat got %h want %h", cnt_s, e.cnt_s);
                end
                led_exp_w = led_of(e.cnt_w);
                led_exp_s = led_of(e.cnt_s);
                led_pend  = 1'b1;
            end
        end
    end

    task automatic hold(input logic [1:0] v, input int n);
        rotary_in = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic detent(input bit dir_cw, input bit with_clear);
        exp_t e;
        if (dir_cw) begin
            hold(2'b01, 10); hold(2'b11, 10); hold(2'b10, 10);
            model_w = model_w + 8'd1;
            model_s = (model_s == 8'hFF) ? 8'hFF : model_s + 8'd1;
        end else begin
            hold(2'b10, 10); hold(2'b11, 10); hold(2'b01, 10);
            model_w = model_w - 8'd1;
            model_s = (model_s == 8'h00) ? 8'h00 : model_s - 8'd1;
        end
        if (with_clear) begin
            model_w = 8'h00;
            model_s = 8'h00;
        end
        rotary_in = 2'b00;
        e.cw = dir_cw; e.cnt_w = model_w; e.cnt_s = model_s; e.due = cyc + 8;
        sb.push_back(e);
        if (with_clear) begin
            repeat (7) @(negedge clk);
            clear = 1'b1;
            @(negedge clk);
            clear = 1'b0;
            repeat (2) @(negedge clk);
        end else begin
            repeat (10) @(negedge clk);
        end
    endtask

    task automatic check_idle(input string name, input int p0);
        compared++;
        if (n_pulses !== p0) begin
            mismatched++;
            $display("FAIL %s_pulses got %0d want %0d", name, n_pulses, p0);
        end
        compared++;
        if (cnt_w !== model_w || cnt_s !== model_s) begin
            mismatched++;
            $display("FAIL %s_count got %h/%h want %h/%h",
                     name, cnt_w, cnt_s, model_w, model_s);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        rotary_in = 2'b00;
        repeat (3) @(negedge clk);
        compared++;
        if (cnt_w !== 8'h00 || cnt_s !== 8'h00) begin
            mismatched++;
            $display("FAIL reset_count got %h/%h want 00/00", cnt_w, cnt_s);
        end
        compared++;
        if ({cw_w, ccw_w, cw_s, ccw_s} !== 4'b0000) begin
            mismatched++;
            $display("FAIL reset_pulse got %b%b%b%b want 0000", cw_w, ccw_w, cw_s, ccw_s);
        end
        compared++;
        if (led_w !== {7'h40, 7'h40} || led_s !== {7'h40, 7'h40}) begin
            mismatched++;
            $display("FAIL reset_led got %h/%h want %h", led_w, led_s, {7'h40, 7'h40});
        end
        model_w = 8'h00;
        model_s = 8'h00;
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_cw_detent;
        int p0 = n_pulses;
        detent(1'b1, 1'b0);
        check_idle("cw_detent", p0 + 1);
        compared++;
        if (led_w[6:0] !== 7'h79) begin
            mismatched++;
            $display("FAIL cw_led0 got %h want 79", led_w[6:0]);
        end
    endtask

    task automatic test_glitch;
        int p0 = n_pulses;
        hold(2'b01, 3);
        hold(2'b00, 20);
        check_idle("glitch", p0);
    endtask

    task automatic test_wrap_saturate;
        int p0 = n_pulses;
        detent(1'b0, 1'b0);
        detent(1'b0, 1'b0);
        detent(1'b1, 1'b0);
        check_idle("wrap_sat", p0 + 3);
    endtask

    task automatic test_half_reversal;
        int p0 = n_pulses;
        hold(2'b01, 10); hold(2'b11, 10);
        hold(2'b01, 10); hold(2'b00, 20);
        check_idle("half_rev", p0);
        detent(1'b1, 1'b0);
        check_idle("half_rev_detent", p0 + 1);
    endtask

    task automatic test_invalid_jump;
        int p0 = n_pulses;
        hold(2'b11, 20);
        hold(2'b00, 20);
        check_idle("invalid_jump", p0);
    endtask

    task automatic test_clear;
        int p0 = n_pulses;
        int n = 0;
        while (model_w != 8'h05 && n < 300) begin
            detent(1'b1, 1'b0);
            n++;
        end
        detent(1'b1, 1'b1);
        check_idle("clear", p0 + n + 1);
    endtask

    task automatic test_reset_mid_detent;
        int p0;
        hold(2'b01, 10);
        hold(2'b11, 10);
        test_reset;
        p0 = n_pulses;
        repeat (10) @(negedge clk);
        detent(1'b1, 1'b0);
        check_idle("reset_mid", p0 + 1);
    endtask

    initial begin
        @(negedge clk);
        test_reset;
        test_cw_detent;
        test_glitch;
        test_wrap_saturate;
        test_half_reversal;
        test_invalid_jump;
        test_clear;
        test_reset_mid_detent;
        repeat (5) @(negedge clk);
        compared++;
        if (sb.size() !== 0) begin
            mismatched++;
            $display("FAIL missing_pulses got %0d pending want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
